// File: rtl/gate_checker_if.sv
// Bus between the checker and its surroundings: run control, status, and the
// stimulus/response pair for the gates unit under test.
interface gate_checker_if;
  logic       start;
  logic       a_out;
  logic       b_out;
  logic [6:0] dut_res;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;
  logic [6:0] fail_bits;

  modport master (
    output start, dut_res,
    input  a_out, b_out, busy, done, pass, err_cnt, fail_vec, fail_bits
  );

  modport slave (
    input  start, dut_res,
    output a_out, b_out, busy, done, pass, err_cnt, fail_vec, fail_bits
  );
endinterface

// File: rtl/gate_checker.sv
// Exhaustive checker for a two-input gates unit: drives all four {a,b} vectors,
// waits for the unit to settle, compares its seven outputs and records errors.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// SETTLE | current vector driven, waiting SETTLE_CYCLES cycles
// CHECK  | one cycle; dut_res compared against the expected gate outputs
// DONE   | one cycle; done pulse, pass updated
module gate_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  gate_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vi_q, vi_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic [2:0] err_q, err_d;
  logic [1:0] fvec_q, fvec_d;
  logic [6:0] fbits_q, fbits_d;
  logic       pass_q, pass_d;

  logic       a, b;
  logic [6:0] expected;
  logic [6:0] diff;

  // ab_q holds the current vector in SETTLE/CHECK, so it doubles as the
  // reference for the expected gate outputs.
  assign a        = ab_q[1];
  assign b        = ab_q[0];
  assign expected = {~a, a | b, ~(a | b), a & b, ~(a & b), a ^ b, ~(a ^ b)};
  assign diff     = bus.dut_res ^ expected;

  always_comb begin
    state_d = state_q;
    vi_d    = vi_q;
    cnt_d   = cnt_q;
    ab_d    = 2'b00;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fbits_d = fbits_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETTLE;
          vi_d    = 2'd0;
          cnt_d   = 4'd0;
          err_d   = 3'd0;
          fvec_d  = 2'b00;
          fbits_d = 7'd0;
          pass_d  = 1'b0;
        end
      end
      SETTLE: begin
        ab_d  = vi_q;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = CHECK;
      end
      CHECK: begin
        if (|diff) begin
          err_d = err_q + 3'd1;
          if (err_q == 3'd0) begin
            fvec_d  = vi_q;
            fbits_d = diff;
          end
        end
        if (vi_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = SETTLE;
          vi_d    = vi_q + 2'd1;
          cnt_d   = 4'd0;
          ab_d    = vi_q + 2'd1;
        end
      end
      DONE: begin
        pass_d  = (err_q == 3'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vi_q    <= 2'd0;
      cnt_q   <= 4'd0;
      ab_q    <= 2'b00;
      err_q   <= 3'd0;
      fvec_q  <= 2'b00;
      fbits_q <= 7'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vi_q    <= vi_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fbits_q <= fbits_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.a_out     = ab_q[1];
  assign bus.b_out     = ab_q[0];
  assign bus.busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_cnt   = err_q;
  assign bus.fail_vec  = fvec_q;
  assign bus.fail_bits = fbits_q;

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: a gates model with selectable faults feeds
// two checkers (SETTLE_CYCLES=2 and 1); timing, vectors and results are checked.
module tb_gate_checker;

  logic clk;
  logic rst_n;
  logic [1:0] mode;
  logic sel;
  int n_checks;
  int n_errors;

  gate_checker_if bus_s2 ();
  gate_checker_if bus_s1 ();

  gate_checker #(.SETTLE_CYCLES(2)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(bus_s2.slave));
  gate_checker #(.SETTLE_CYCLES(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(bus_s1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0 correct, 1 i_xnor stuck 0, 2 f_and inverted, 3 d_or stuck 0
  function automatic logic [6:0] gates(input logic a, input logic b, input logic [1:0] m);
    logic [6:0] r;
    r = {~a, a | b, ~(a | b), a & b, ~(a & b), a ^ b, ~(a ^ b)};
    case (m)
      2'd1: r[0] = 1'b0;
      2'd2: r[3] = ~r[3];
      2'd3: r[5] = 1'b0;
      default: ;
    endcase
    return r;
  endfunction

  assign bus_s2.dut_res = gates(bus_s2.a_out, bus_s2.b_out, mode);
  assign bus_s1.dut_res = gates(bus_s1.a_out, bus_s1.b_out, mode);

  logic       m_done, m_busy;
  logic [1:0] m_ab;
  always_comb begin
    m_done = sel ? bus_s1.done : bus_s2.done;
    m_busy = sel ? bus_s1.busy : bus_s2.busy;
    m_ab   = sel ? {bus_s1.a_out, bus_s1.b_out} : {bus_s2.a_out, bus_s2.b_out};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) bus_s1.start = v;
    else     bus_s2.start = v;
  endtask

  // Starts a run in the current cycle (T) and follows it to done.
  task automatic run(input string tag, input int lat_exp, input int repulse_k, input bit hold);
    int per, lat, bad, extra;
    logic       e_busy;
    logic [1:0] e_ab;
    per = sel ? 2 : 3;
    lat = 0;
    bad = 0;
    extra = 0;
    @(negedge clk);
    set_start(1'b1);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      e_busy = (k <= 4 * per);
      e_ab   = e_busy ? 2'((k - 1) / per) : 2'b00;
      if (m_ab !== e_ab || m_busy !== e_busy) bad++;
      if (k == 1 && !hold) set_start(1'b0);
      if (repulse_k != 0 && k == repulse_k) set_start(1'b1);
      if (repulse_k != 0 && k == repulse_k + 1) set_start(1'b0);
      if (m_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, lat_exp);
    chk({tag, "_vec"}, bad, 0);
    if (!hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (m_done !== 1'b0 || m_busy !== 1'b0 || m_ab !== 2'b00) extra++;
      end
      chk({tag, "_idle"}, extra, 0);
    end
  endtask

  task automatic chk_res(input string tag, input logic p, input logic [2:0] e,
                         input logic [1:0] fv, input logic [6:0] fb);
    if (sel) begin
      chk({tag, "_pass"}, bus_s1.pass, p);
      chk({tag, "_err"}, bus_s1.err_cnt, e);
      chk({tag, "_fvec"}, bus_s1.fail_vec, fv);
      chk({tag, "_fbits"}, bus_s1.fail_bits, fb);
    end else begin
      chk({tag, "_pass"}, bus_s2.pass, p);
      chk({tag, "_err"}, bus_s2.err_cnt, e);
      chk({tag, "_fvec"}, bus_s2.fail_vec, fv);
      chk({tag, "_fbits"}, bus_s2.fail_bits, fb);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ab"}, {bus_s2.a_out, bus_s2.b_out}, 2'b00);
    chk({tag, "_busy"}, bus_s2.busy, 1'b0);
    chk({tag, "_done"}, bus_s2.done, 1'b0);
    chk_res(tag, 1'b0, 3'd0, 2'b00, 7'd0);
  endtask

  initial begin
    int bad, lat;
    n_checks = 0;
    n_errors = 0;
    mode = 2'd0;
    sel = 1'b0;
    rst_n = 1'b0;
    bus_s2.start = 1'b0;
    bus_s1.start = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("ok", 13, 0, 0);
    chk_res("ok", 1'b1, 3'd0, 2'b00, 7'h00);
    mode = 2'd1;
    run("xnor0", 13, 0, 0);
    chk_res("xnor0", 1'b0, 3'd2, 2'b00, 7'h01);
    mode = 2'd2;
    run("andinv", 13, 0, 0);
    chk_res("andinv", 1'b0, 3'd4, 2'b00, 7'h08);
    mode = 2'd3;
    run("or0", 13, 0, 0);
    chk_res("or0", 1'b0, 3'd3, 2'b01, 7'h20);
    mode = 2'd0;
    run("repulse", 13, 5, 0);
    chk_res("repulse", 1'b1, 3'd0, 2'b00, 7'h00);

    // Reset during SETTLE of vector 10, with two errors already counted
    mode = 2'd2;
    @(negedge clk);
    bus_s2.start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) bus_s2.start = 1'b0;
    end
    chk("mid_ab", {bus_s2.a_out, bus_s2.b_out}, 2'b10);
    chk("mid_err", bus_s2.err_cnt, 3'd2);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus_s2.done !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_s2.done !== 1'b0 || bus_s2.busy !== 1'b0) bad++;
    end
    chk("mid_nodone", bad, 0);
    mode = 2'd0;
    run("fresh", 13, 0, 0);
    chk_res("fresh", 1'b1, 3'd0, 2'b00, 7'h00);

    // start held high through DONE restarts immediately
    mode = 2'd2;
    run("hold", 13, 0, 1);
    chk("hold_err_done", bus_s2.err_cnt, 3'd4);
    mode = 2'd0;
    @(negedge clk);
    chk("hold_idle_busy", bus_s2.busy, 1'b0);
    chk("hold_idle_err", bus_s2.err_cnt, 3'd4);
    @(negedge clk);
    bus_s2.start = 1'b0;
    chk("hold_acc_busy", bus_s2.busy, 1'b1);
    chk("hold_acc_err", bus_s2.err_cnt, 3'd0);
    lat = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (bus_s2.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("hold2_lat", lat, 13);
    @(negedge clk);
    chk_res("hold2", 1'b1, 3'd0, 2'b00, 7'h00);

    sel = 1'b1;
    run("s1_ok", 9, 0, 0);
    chk_res("s1_ok", 1'b1, 3'd0, 2'b00, 7'h00);
    mode = 2'd1;
    run("s1_xnor0", 9, 0, 0);
    chk_res("s1_xnor0", 1'b0, 3'd2, 2'b00, 7'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, range 1..15: cycles each input vector is held before the checker samples the gates unit's outputs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 a_out  output  1  stimulus bit a driven to the gates unit under test.
REQ-006 b_out  output  1  stimulus bit b driven to the gates unit under test.
REQ-007 dut_res  input  7  gates unit results {c_not,d_or,e_nor,f_and,g_nand,h_xor,i_xnor}, bit6..bit0.
REQ-008 busy  output  1  high from the cycle after start is accepted through the last CHECK cycle.
REQ-009 done  output  1  one-cycle pulse, run complete.
REQ-010 pass  output  1  1 when the last completed run had zero mismatching vectors.
REQ-011 err_cnt  output  3  count of mismatching vectors in current/last run, 0..4.
REQ-012 fail_vec  output  2  {a,b} of the first mismatching vector.
REQ-013 fail_bits  output  7  dut_res XOR expected for the first mismatching vector.

Function
REQ-014 FSM states: IDLE, SETTLE, CHECK, DONE; a 2-bit vector index vi and a 4-bit settle counter.
REQ-015 IDLE: start=1 -> SETTLE next cycle; vi=0; err_cnt, fail_vec, fail_bits, pass cleared to 0; settle counter cleared.
REQ-016 Vector order by vi: 0 -> {a,b}=00, 1 -> 01, 2 -> 10, 3 -> 11; {a_out,b_out} are registered and equal the current vector in SETTLE and CHECK.
REQ-017 SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles in SETTLE -> CHECK.
REQ-018 CHECK (one cycle): expected = {~a, a|b, ~(a|b), a&b, ~(a&b), a^b, ~(a^b)} for the current vector; dut_res compared against it in that cycle.
REQ-019 Mismatch in CHECK: err_cnt increments; if err_cnt was 0, fail_vec = current vector and fail_bits = dut_res XOR expected; later mismatches do not overwrite them.
REQ-020 CHECK exit: vi<3 -> vi+1, counter cleared, SETTLE; vi=3 -> DONE.
REQ-021 DONE (one cycle): done=1, busy=0, {a_out,b_out}=00, pass = (err_cnt==0 including the final CHECK); then IDLE.
REQ-022 Latency: start accepted at cycle T -> done high at T+1+4*(SETTLE_CYCLES+1).
REQ-023 start while not in IDLE is ignored; start held high in IDLE after DONE begins a new run.
REQ-024 pass, err_cnt, fail_vec, fail_bits hold their values in IDLE until the next accepted start.
REQ-025 In IDLE {a_out,b_out}=00 and busy=0.
REQ-026 dut_res with X/Z is a mismatch on those bits is not required; bench drives only 0/1.

Reset
REQ-027 rst_n low, at any time including mid-run: state IDLE immediately; a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=00, fail_bits=0000000, vi=0, counter=0.
REQ-028 After rst_n deasserts, the first accepted start begins at vector 00; no partial run resumes.

Verification
REQ-029 Correct gates model, SETTLE_CYCLES=2, start pulse at T -> vectors 00,01,10,11 each held 3 cycles; done at T+13; pass=1, err_cnt=0, fail_bits=0000000.
REQ-030 Model with i_xnor stuck at 0 -> err_cnt=2, pass=0, fail_vec=00, fail_bits=0000001.
REQ-031 Model with f_and inverted -> err_cnt=4, fail_vec=00, fail_bits=0001000.
REQ-032 rst_n pulsed low during vector 10 SETTLE -> all outputs zero asynchronously, no done pulse; fresh start completes normally with pass=1.
REQ-033 start re-pulsed while busy -> ignored, single done at T+13; start held high through DONE -> second run starts, err_cnt cleared on acceptance.
REQ-034 SETTLE_CYCLES=1, correct model -> done at T+9, pass=1.
